idct_befifft_pre: RTL
=====================

IDCT_BEFIFFT_PRE -- requirements
Module: idct_befifft_pre

Interface
REQ-001 SHALL have parameter wDataInOut, default 16, the data width of sink_real, source_real and source_imag.
REQ-002 SHALL have parameter wTwid, default 16, the signed Q1.(wTwid-1) twiddle width.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst_sync  in  1  synchronous, active-high reset.
REQ-005 sink_valid/sink_sop/sink_eop  in  1 each  input frame of real DCT coefficients D(k), k=0..N-1, natural order.
REQ-006 sink_ready  out  1  registered; high means the block accepts input.
REQ-007 sink_real  in  wDataInOut  signed D(k).
REQ-008 sink_error  in  2  ignored.
REQ-009 fftpts_in  in  12  N, one of 32/64/128/256/512/1024/2048.
REQ-010 source_valid/source_sop/source_eop  out  1 each  output frame F(k), k=0..N-1, natural order.
REQ-011 source_ready  in  1  downstream IFFT ready.
REQ-012 source_real/source_imag  out  wDataInOut each  signed F(k).
REQ-013 source_error  out  2  constant 2'b00.
REQ-014 fftpts_out  out  12  N latched for the current frame.

Function
REQ-015 SHALL compute F(0) = D(0)*K0, where K0 = round(2^(wTwid-1)/sqrt2) (23170 for wTwid=16), and F(0) imag = 0.
REQ-016 SHALL, for k>=1, compute F(k) = (D(k) - j*D(N-k)) * (c + j*s), where c + j*s = exp(j*pi*k/(2N)).
REQ-017 The k>=1 case SHALL expand to real = a*c + b*s and imag = a*s - b*c, with a = D(k) and b = D(N-k).
REQ-018 The global sqrt(N/2) factor SHALL be omitted; downstream IFFT scaling absorbs it.
REQ-019 SHALL keep full-precision products and sums, round half-up, shift right by wTwid-1, then saturate to wDataInOut signed.
REQ-020 SHALL use FSM states WAIT, WRITE, WAIT_RDY and READ.
REQ-021 WAIT -> WRITE on sink_valid & sink_sop.
REQ-022 WRITE -> WAIT_RDY on sink_valid & sink_eop.
REQ-023 WAIT_RDY -> READ when source_ready = 1.
REQ-024 READ -> WAIT after the issue of address k = N-1.
REQ-025 sink_ready SHALL be 1 in WAIT and WRITE and 0 in WAIT_RDY and READ, registered one cycle after the state change.
REQ-026 SHALL latch fftpts_in on the accepted sop; unsupported values SHALL be treated as 2048.
REQ-027 Write counter SHALL reset to 0 at each sop; a sample SHALL be written only when count < N.
REQ-028 Samples beyond N before eop SHALL be dropped.
REQ-029 An early eop SHALL close the frame; unwritten entries keep stale contents.
REQ-030 An sop seen while in WRITE SHALL restart the count at 0.
REQ-031 READ SHALL issue one k per cycle with no bubbles, using read address A = k and read address B = (N-k) mod N.
REQ-032 b SHALL be forced to 0 when k = 0.
REQ-033 Twiddle index SHALL be k*(2048/N).
REQ-034 Latency SHALL be fixed at 3 cycles from issue of k to F(k) on the source outputs: RAM/ROM read, then product register, then sum/round/saturate register.
REQ-035 source_sop SHALL be high with F(0) and source_eop with F(N-1); source_valid SHALL be continuous for N cycles.
REQ-036 source_ready SHALL be sampled only in WAIT_RDY; deassertion during READ is ignored.
REQ-037 The frame SHALL be fully stored before any output (no write/read overlap).

Reset
REQ-038 On rst_sync = 1, the next edge SHALL set the FSM to WAIT and all counters to 0.
REQ-039 On rst_sync = 1, sink_ready, source_valid, source_sop, source_eop, source_real and source_imag SHALL be 0, and fftpts_out SHALL be 2048.
REQ-040 Reset mid-frame SHALL abort the frame with no further output.
REQ-041 RAM contents SHALL NOT be cleared by reset.

Structure
REQ-042 Shared package SHALL hold FSM state encodings, the supported-N list, MAX_N=2048 and K0.
REQ-043 Sub-module idct_twiddle_rom SHALL provide an 11-bit index, a 1-cycle registered output, and cos/sin of pi*m/4096 for m = 0..2047, each wTwid bits.
REQ-044 Storage SHALL be two identical inferred 2048 x wDataInOut simple-dual-port RAMs, written together and read at addresses A and B respectively.

Verification
REQ-045 N=32, D(0)=16384, rest 0 -> F(0) = (11585, 0); F(1..31) = (0, 0).
REQ-046 N=32, D(1)=8192, rest 0 -> F(1) = (8182, 402); F(31) = (8182, -402); all others (0, 0).
REQ-047 N=32, D(16)=32767, rest 0 -> F(16) real saturates to 32767, imag = 0.
REQ-048 source_ready held 0 for 10 cycles after eop -> no source_valid and sink_ready=0 during the hold; then source_ready=1 -> source_sop exactly 4 cycles later; exactly 32 valid cycles.
REQ-049 rst_sync pulsed at k=10 of READ -> all outputs 0 next cycle; sink_ready=1 one cycle after release; next frame correct.
REQ-050 Back-to-back frames N=2048 then N=64 -> output lengths 2048 and 64; fftpts_out tracks each frame; N=64 twiddles match a stride-32 reference model.

Source files
------------

// File: rtl/idct_befifft_pre_pkg.sv
// Shared constants and helpers for the IDCT pre-IFFT rotation block.
// Holds FSM encodings, supported frame sizes, K0 and twiddle generation.
package idct_befifft_pre_pkg;

  localparam logic [1:0] S_WAIT     = 2'd0;
  localparam logic [1:0] S_WRITE    = 2'd1;
  localparam logic [1:0] S_WAIT_RDY = 2'd2;
  localparam logic [1:0] S_READ     = 2'd3;

  localparam int MAX_N = 2048;
  localparam real PI = 3.14159265358979323846;

  localparam logic [11:0] N_LIST [7] = '{
    12'd32, 12'd64, 12'd128, 12'd256,
    12'd512, 12'd1024, 12'd2048
  };

  function automatic logic [11:0] legal_n(input logic [11:0] n);
    for (int i = 0; i < 7; i++)
      if (n == N_LIST[i]) return n;
    return 12'(MAX_N);
  endfunction

  // log2(2048/N), the twiddle stride as a shift
  function automatic logic [2:0] n_shift(input logic [11:0] n);
    for (int i = 0; i < 7; i++)
      if (n == N_LIST[i]) return 3'(6 - i);
    return 3'd0;
  endfunction

  // round(2^(w-1)/sqrt2) == round(sqrt(2^(2w-3)))
  function automatic int k0_val(input int w);
    longint x, r, lo, hi, mid;
    x  = longint'(1) << (2 * w - 3);
    lo = 0;
    hi = longint'(1) << w;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= x) lo = mid;
      else hi = mid - 1;
    end
    r = lo;
    if (x - r * r > r) r = r + 1;
    return int'(r);
  endfunction

  localparam int K0 = k0_val(16);

  function automatic int twid_q(input int m, input bit is_sin,
                                input int w);
    real ang, x;
    int q, lim;
    ang = PI * real'(m) / 4096.0;
    x   = is_sin ? $sin(ang) : $cos(ang);
    lim = (1 << (w - 1)) - 1;
    q   = int'(x * real'(1 << (w - 1)));
    if (q > lim) q = lim;
    return q;
  endfunction

endpackage

// File: rtl/idct_befifft_pre_twiddle_rom.sv
// Registered cos/sin ROM of pi*m/4096, m = 0..2047.
// Table contents are fixed at elaboration.
module idct_twiddle_rom
  import idct_befifft_pre_pkg::*;
#(
  parameter int wTwid = 16
) (
  input  logic                    clk,
  input  logic [10:0]             idx,
  output logic signed [wTwid-1:0] cos_q,
  output logic signed [wTwid-1:0] sin_q
);

  logic signed [wTwid-1:0] cos_tab [MAX_N];
  logic signed [wTwid-1:0] sin_tab [MAX_N];

  for (genvar m = 0; m < MAX_N; m++) begin : g_tab
    assign cos_tab[m] = wTwid'(twid_q(m, 1'b0, wTwid));
    assign sin_tab[m] = wTwid'(twid_q(m, 1'b1, wTwid));
  end

  always_ff @(posedge clk) begin
    cos_q <= cos_tab[idx];
    sin_q <= sin_tab[idx];
  end

endmodule

// File: rtl/idct_befifft_pre.sv
// Buffers one frame of DCT coefficients and emits the rotated
// complex sequence F(k) that feeds an IFFT-based IDCT.
module idct_befifft_pre
  import idct_befifft_pre_pkg::*;
#(
  parameter int wDataInOut = 16,
  parameter int wTwid      = 16
) (
  input  logic                         clk,
  input  logic                         rst_sync,
  input  logic                         sink_valid,
  input  logic                         sink_sop,
  input  logic                         sink_eop,
  output logic                         sink_ready,
  input  logic signed [wDataInOut-1:0] sink_real,
  input  logic [1:0]                   sink_error,
  input  logic [11:0]                  fftpts_in,
  output logic                         source_valid,
  output logic                         source_sop,
  output logic                         source_eop,
  input  logic                         source_ready,
  output logic signed [wDataInOut-1:0] source_real,
  output logic signed [wDataInOut-1:0] source_imag,
  output logic [1:0]                   source_error,
  output logic [11:0]                  fftpts_out
);

  localparam int DW = wDataInOut;
  localparam int TW = wTwid;
  localparam int PW = DW + TW;
  localparam int SW = PW + 1;

  localparam logic signed [TW-1:0] K0Q = TW'(k0_val(TW));
  localparam logic signed [SW-1:0] HALF = SW'(1) << (TW - 2);

  logic [1:0]  state, nxt;
  logic [11:0] cnt, n_reg, n_m1;
  logic [2:0]  sh;
  logic [10:0] k, addr_b, tw_idx, wr_addr;
  logic        wr_en, sop_acc, k_last;
  logic        unused_ok;

  assign unused_ok    = ^sink_error;
  assign source_error = 2'b00;
  assign fftpts_out   = n_reg;

  assign sop_acc = sink_valid & sink_sop;
  assign n_m1    = n_reg - 12'd1;
  assign k_last  = ({1'b0, k} == n_m1);
  assign addr_b  = 11'((n_reg - {1'b0, k}) & n_m1);
  assign tw_idx  = k << sh;

  always_comb begin
    nxt     = state;
    wr_en   = 1'b0;
    wr_addr = cnt[10:0];
    unique case (state)
      S_WAIT: begin
        if (sop_acc) begin
          nxt     = S_WRITE;
          wr_en   = 1'b1;
          wr_addr = '0;
        end
      end
      S_WRITE: begin
        if (sop_acc) begin
          wr_en   = 1'b1;
          wr_addr = '0;
        end else if (sink_valid && cnt < n_reg) begin
          wr_en = 1'b1;
        end
        if (sink_valid && sink_eop) nxt = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (source_ready) nxt = S_READ;
      end
      S_READ: begin
        if (k_last) nxt = S_WAIT;
      end
      default: nxt = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state      <= S_WAIT;
      cnt        <= '0;
      k          <= '0;
      n_reg      <= 12'(MAX_N);
      sh         <= '0;
      sink_ready <= 1'b0;
    end else begin
      state      <= nxt;
      sink_ready <= (state == S_WAIT) || (state == S_WRITE);
      if (sop_acc && (state == S_WAIT || state == S_WRITE)) begin
        cnt   <= 12'd1;
        n_reg <= legal_n(fftpts_in);
        sh    <= n_shift(legal_n(fftpts_in));
      end else if (state == S_WRITE && sink_valid && cnt < n_reg) begin
        cnt <= cnt + 12'd1;
      end
      if (state == S_READ) k <= k_last ? '0 : k + 11'd1;
      else k <= '0;
    end
  end

  // Twin RAMs so D(k) and D(N-k) are read in the same cycle
  logic signed [DW-1:0] ram_a [MAX_N];
  logic signed [DW-1:0] ram_b [MAX_N];
  logic signed [DW-1:0] rd_a, rd_b;
  logic signed [TW-1:0] tw_c, tw_s;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      ram_a[wr_addr] <= sink_real;
      ram_b[wr_addr] <= sink_real;
    end
    rd_a <= ram_a[k];
    rd_b <= ram_b[addr_b];
  end

  idct_twiddle_rom #(.wTwid(TW)) u_rom (
    .clk   (clk),
    .idx   (tw_idx),
    .cos_q (tw_c),
    .sin_q (tw_s)
  );

  logic v1, v2, sop1, sop2, eop1, eop2, z1;
  logic signed [PW-1:0] a_x, b_x, c_x, s_x;
  logic signed [PW-1:0] p_ac, p_bs, p_as, p_bc;
  logic signed [SW-1:0] sum_re, sum_im, rnd_re, rnd_im;

  // k = 0 reuses the same multipliers: b = 0, c = K0, s = sin(0) = 0
  assign a_x = PW'(rd_a);
  assign b_x = z1 ? '0 : PW'(rd_b);
  assign c_x = z1 ? PW'(K0Q) : PW'(tw_c);
  assign s_x = PW'(tw_s);

  always_ff @(posedge clk) begin
    p_ac <= a_x * c_x;
    p_bs <= b_x * s_x;
    p_as <= a_x * s_x;
    p_bc <= b_x * c_x;
  end

  assign sum_re = SW'(p_ac) + SW'(p_bs);
  assign sum_im = SW'(p_as) - SW'(p_bc);
  assign rnd_re = (sum_re + HALF) >>> (TW - 1);
  assign rnd_im = (sum_im + HALF) >>> (TW - 1);

  function automatic logic signed [DW-1:0] sat(
    input logic signed [SW-1:0] x
  );
    logic signed [SW-1:0] hi, lo;
    hi = SW'({1'b0, {(DW-1){1'b1}}});
    lo = ~hi;
    if (x > hi) return hi[DW-1:0];
    if (x < lo) return lo[DW-1:0];
    return x[DW-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      v1           <= 1'b0;
      v2           <= 1'b0;
      sop1         <= 1'b0;
      sop2         <= 1'b0;
      eop1         <= 1'b0;
      eop2         <= 1'b0;
      z1           <= 1'b0;
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      source_real  <= '0;
      source_imag  <= '0;
    end else begin
      v1           <= (state == S_READ);
      sop1         <= (state == S_READ) && (k == '0);
      eop1         <= (state == S_READ) && k_last;
      z1           <= (k == '0);
      v2           <= v1;
      sop2         <= sop1;
      eop2         <= eop1;
      source_valid <= v2;
      source_sop   <= sop2;
      source_eop   <= eop2;
      source_real  <= sat(rnd_re);
      source_imag  <= sat(rnd_im);
    end
  end

endmodule
